apb_slave_mem: RTL

//  APB3 completer (responder) at the far end of the APB master bridge. Holds a word-addressed

---
 rtl/apb_slave_mem.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB3 completer with a word-addressed register memory.
// Every access phase carries WAIT_CYCLES wait states. Addresses at or above
// MEM_DEPTH complete with PSLVERR. pslverr is valid only while pready is high.
// Optional feature macro: APB_SLV_PSTRB_EN adds the pstrb port and byte-lane writes.
// Without the macro, every write replaces the full word.
module apb_slave_mem #(
    parameter int AW          = 8,
    parameter int DW          = 32,
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic            pclk,
    input  logic            preset,
    input  logic            psel,
    input  logic            penable,
    input  logic            pwrite,
    input  logic [AW-1:0]   paddr,
    input  logic [DW-1:0]   pwdata,
`ifdef APB_SLV_PSTRB_EN
    input  logic [DW/8-1:0] pstrb,
`endif
    output logic [DW-1:0]   prdata,
    output logic            pready,
    output logic            pslverr
);

    localparam int            NB      = DW / 8;
    localparam int            IW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(MEM_DEPTH);
    localparam logic [3:0]    WAIT_L  = 4'(WAIT_CYCLES);

    // ST_SETUP is the first access-phase cycle after a setup phase was sampled.
    // ST_ACCESS covers every later wait-state cycle.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic [IW-1:0]   r_idx;
    logic            r_write;
    logic            r_err;
    logic [DW-1:0]   r_wdata;
    logic [NB-1:0]   r_strb;
    logic            r_pready;
    logic            r_pslverr;
    logic [DW-1:0]   r_prdata;
    logic [DW-1:0]   r_mem [MEM_DEPTH];

    logic            w_start;
    logic            w_tick;
    logic            w_done;
    logic            w_abort;
    logic            w_wr_en;
    logic            w_err_in;
    logic [IW-1:0]   w_idx_in;
    logic [NB-1:0]   w_strb_in;

    // Merge the new data into the old word, one byte lane per strobe bit.
    function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] old_w,
                                                  input logic [DW-1:0] new_w,
                                                  input logic [NB-1:0] strb);
        logic [DW-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = new_w[i*8 +: 8];
            end
        end
        return res;
    endfunction

`ifdef APB_SLV_PSTRB_EN
    assign w_strb_in = pstrb;
`else
    assign w_strb_in = {NB{1'b1}};
`endif

    assign w_err_in = ({1'b0, paddr} >= DEPTH_L);
    assign w_idx_in = paddr[IW-1:0];
    assign w_wr_en  = w_done & r_write & ~r_err;

    assign prdata  = r_prdata;
    assign pready  = r_pready;
    assign pslverr = r_pslverr;

    // State register.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle actions: start, wait tick, complete, or abort.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_tick      = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // penable without a preceding setup phase is ignored.
                if (psel && !penable) begin
                    w_state_nxt = ST_SETUP;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP, ST_ACCESS: begin
                if (psel && penable && r_pready) begin
                    w_state_nxt = ST_IDLE;
                    w_done      = 1'b1;
                end else if (!psel) begin
                    w_state_nxt = ST_IDLE;
                    w_abort     = 1'b1;
                end else if (!penable && r_pready) begin
                    // A new setup phase is presented while ready: start the next transfer.
                    w_state_nxt = ST_SETUP;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = ST_ACCESS;
                    w_tick      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture request fields, count wait states, and drive the registered response.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_cnt     <= 4'd0;
            r_idx     <= {IW{1'b0}};
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            r_wdata   <= {DW{1'b0}};
            r_strb    <= {NB{1'b0}};
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= {DW{1'b0}};
        end else if (w_start) begin
            r_cnt   <= WAIT_L;
            r_idx   <= w_idx_in;
            r_write <= pwrite;
            r_err   <= w_err_in;
            r_wdata <= pwdata;
            r_strb  <= w_strb_in;
            if (WAIT_L == 4'd0) begin
                r_pready  <= 1'b1;
                r_pslverr <= w_err_in;
                r_prdata  <= (pwrite || w_err_in) ? {DW{1'b0}} : r_mem[w_idx_in];
            end else begin
                r_pready  <= 1'b0;
                r_pslverr <= 1'b0;
                r_prdata  <= {DW{1'b0}};
            end
        end else if (w_tick) begin
            if (r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_cnt == 4'd1) begin
                r_pready  <= 1'b1;
                r_pslverr <= r_err;
                r_prdata  <= (r_write || r_err) ? {DW{1'b0}} : r_mem[r_idx];
            end
        end else if (w_done || w_abort) begin
            r_cnt     <= 4'd0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= {DW{1'b0}};
        end
    end

    // Memory array, written only on the completing edge of an error-free write.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= {DW{1'b0}};
            end
        end else if (w_wr_en) begin
            r_mem[r_idx] <= merge_lanes(r_mem[r_idx], r_wdata, r_strb);
        end
    end

endmodule
